// File: rtl/reg_bank_gen_pkg.sv
// Shared definitions for the register bank: function-select encodings and
// a select-width helper that never returns zero.
package reg_bank_gen_pkg;

    localparam logic [1:0] FS_CLR  = 2'b00;
    localparam logic [1:0] FS_LOAD = 2'b01;
    localparam logic [1:0] FS_DEC  = 2'b10;
    localparam logic [1:0] FS_INC  = 2'b11;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_bank_gen_reg_cell.sv
// One WIDTH-bit register with clear/load/lane-load/dec/inc and a strobe
// raised when an enabled inc/dec starts at the wrap/clamp boundary.
module reg_cell
    import reg_bank_gen_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               LANE      = 8,
    parameter int               LSW       = 1,
    parameter int               SATURATE  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       funsel,
    input  logic             part,
    input  logic [LSW-1:0]   lane_sel,
    input  logic [WIDTH-1:0] load,
    output logic [WIDTH-1:0] value,
    output logic             hit
);

    localparam int               LANES = WIDTH / LANE;
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [WIDTH-1:0] value_reg;
    logic [WIDTH-1:0] value_next;
    logic [LANES-1:0] lane_hit;

    // An out-of-range lane index matches no lane, so the register holds.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_hit[gi] = (int'(lane_sel) == gi);
    end

    always_comb begin
        value_next = value_reg;
        hit        = 1'b0;
        case (funsel)
            FS_CLR: value_next = '0;
            FS_LOAD: begin
                if (!part) begin
                    value_next = load;
                end else begin
                    for (int l = 0; l < LANES; l++) begin
                        if (lane_hit[l]) value_next[l*LANE +: LANE] = load[LANE-1:0];
                    end
                end
            end
            FS_DEC: begin
                if (value_reg == '0) begin
                    hit        = 1'b1;
                    value_next = (SATURATE != 0) ? '0 : '1;
                end else begin
                    value_next = value_reg - ONE;
                end
            end
            default: begin
                if (value_reg == '1) begin
                    hit        = 1'b1;
                    value_next = (SATURATE != 0) ? '1 : '0;
                end else begin
                    value_next = value_reg + ONE;
                end
            end
        endcase
        if (!en) begin
            value_next = value_reg;
            hit        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) value_reg <= RESET_VAL;
        else        value_reg <= value_next;
    end

    assign value = value_reg;

endmodule

// File: rtl/reg_bank_gen.sv
// Register file of DEPTH reg_cells sharing one operation bus, with two
// combinational read ports and a registered boundary-event pulse.
module reg_bank_gen
    import reg_bank_gen_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               DEPTH     = 4,
    parameter int               LANE      = 8,
    parameter int               SATURATE  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              LSW       = clog2_min1(WIDTH / LANE),
    localparam int              SSW       = clog2_min1(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DEPTH-1:0] en_mask,
    input  logic [1:0]       funsel,
    input  logic             part,
    input  logic [LSW-1:0]   lane_sel,
    input  logic [WIDTH-1:0] load,
    input  logic [SSW-1:0]   sel_a,
    input  logic [SSW-1:0]   sel_b,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             bound_evt
);

    logic [DEPTH-1:0][WIDTH-1:0] reg_value;
    logic [DEPTH-1:0]            cell_hit;
    logic                        bound_evt_reg;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
        reg_cell #(
            .WIDTH     (WIDTH),
            .LANE      (LANE),
            .LSW       (LSW),
            .SATURATE  (SATURATE),
            .RESET_VAL (RESET_VAL)
        ) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en_mask[gi]),
            .funsel   (funsel),
            .part     (part),
            .lane_sel (lane_sel),
            .load     (load),
            .value    (reg_value[gi]),
            .hit      (cell_hit[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) bound_evt_reg <= 1'b0;
        else        bound_evt_reg <= |cell_hit;
    end

    assign bound_evt = bound_evt_reg;

    // Selects beyond DEPTH match nothing and read as zero.
    always_comb begin
        out_a = '0;
        out_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(sel_a) == i) out_a = reg_value[i];
            if (int'(sel_b) == i) out_b = reg_value[i];
        end
    end

endmodule

// File: tb/tb_reg_bank_gen.sv
// Directed bench for reg_bank_gen: a wrapping bank (RESET_VAL=0) and a
// saturating bank (RESET_VAL=0xA5A5) share stimulus; expectations are queued.
module tb_reg_bank_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  en_mask;
    logic [1:0]  funsel;
    logic        part;
    logic [0:0]  lane_sel;
    logic [15:0] load;
    logic [1:0]  sel_a, sel_b;
    logic [15:0] out_a_w, out_b_w, out_a_s, out_b_s;
    logic        evt_w, evt_s;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        int          dutn;   // 0 = wrap bank, 1 = saturate bank
        int          kind;   // 0 = via out_a, 1 = via out_b, 2 = bound_evt
        int          idx;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    reg_bank_gen #(.WIDTH(16), .DEPTH(4), .LANE(8), .SATURATE(0), .RESET_VAL(16'h0000)) dut_w (
        .clk(clk), .rst_n(rst_n), .en_mask(en_mask), .funsel(funsel), .part(part),
        .lane_sel(lane_sel), .load(load), .sel_a(sel_a), .sel_b(sel_b),
        .out_a(out_a_w), .out_b(out_b_w), .bound_evt(evt_w)
    );

    reg_bank_gen #(.WIDTH(16), .DEPTH(4), .LANE(8), .SATURATE(1), .RESET_VAL(16'hA5A5)) dut_s (
        .clk(clk), .rst_n(rst_n), .en_mask(en_mask), .funsel(funsel), .part(part),
        .lane_sel(lane_sel), .load(load), .sel_a(sel_a), .sel_b(sel_b),
        .out_a(out_a_s), .out_b(out_b_s), .bound_evt(evt_s)
    );

    task automatic push(input string tag, input int dutn, input int kind, input int idx,
                        input logic [15:0] exp);
        exp_t e;
        e.tag = tag; e.dutn = dutn; e.kind = kind; e.idx = idx; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic exp_reg(input string tag, input int dutn, input int idx, input logic [15:0] v);
        push(tag, dutn, 0, idx, v);
    endtask

    task automatic exp_both(input string tag, input int idx, input logic [15:0] v);
        push(tag, 0, 0, idx, v);
        push(tag, 1, 0, idx, v);
    endtask

    task automatic exp_evt(input string tag, input logic vw, input logic vs);
        push(tag, 0, 2, 0, {15'd0, vw});
        push(tag, 1, 2, 0, {15'd0, vs});
    endtask

    task automatic drive(input logic rn, input logic [3:0] m, input logic [1:0] fs,
                         input logic p, input logic ls, input logic [15:0] d);
        rst_n = rn; en_mask = m; funsel = fs; part = p; lane_sel = ls; load = d;
    endtask

    // Advance one edge, then pop and check every queued expectation.
    task automatic tick();
        exp_t e;
        logic [15:0] obs;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.kind == 0) sel_a = e.idx[1:0];
            else if (e.kind == 1) sel_b = e.idx[1:0];
            #1;
            case (e.kind)
                0:       obs = (e.dutn == 0) ? out_a_w : out_a_s;
                1:       obs = (e.dutn == 0) ? out_b_w : out_b_s;
                default: obs = {15'd0, (e.dutn == 0) ? evt_w : evt_s};
            endcase
            vectors++;
            assert (obs === e.exp)
            else begin
                miscompares++;
                $error("FAIL %s dut%0d kind%0d r%0d: observed %h expected %h",
                       e.tag, e.dutn, e.kind, e.idx, obs, e.exp);
            end
            $display("check %s dut%0d kind%0d r%0d obs=%h exp=%h", e.tag, e.dutn, e.kind,
                     e.idx, obs, e.exp);
        end
    endtask

    initial begin
        sel_a = 2'd0; sel_b = 2'd0;
        // Reset with a pending increment: reset value wins.
        drive(1'b0, 4'hF, 2'b11, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            exp_reg("reset", 0, i, 16'h0000);
            exp_reg("reset", 1, i, 16'hA5A5);
        end
        exp_evt("reset_evt", 1'b0, 1'b0);
        tick();

        // Masked full load.
        drive(1'b1, 4'b0101, 2'b01, 1'b0, 1'b0, 16'h1234);
        exp_both("mask_load_r0", 0, 16'h1234);
        exp_both("mask_load_r2", 2, 16'h1234);
        exp_reg("mask_hold_r1", 0, 1, 16'h0000);
        exp_reg("mask_hold_r1", 1, 1, 16'hA5A5);
        exp_reg("mask_hold_r3", 0, 3, 16'h0000);
        exp_reg("mask_hold_r3", 1, 3, 16'hA5A5);
        tick();

        // Clear goes to zero, not RESET_VAL.
        drive(1'b1, 4'b0001, 2'b00, 1'b0, 1'b0, 16'hFFFF);
        exp_both("clr_r0", 0, 16'h0000);
        exp_both("clr_hold_r2", 2, 16'h1234);
        tick();

        // Lane loads on R1.
        drive(1'b1, 4'b0010, 2'b01, 1'b0, 1'b0, 16'h1234);
        exp_both("r1_full", 1, 16'h1234);
        tick();
        drive(1'b1, 4'b0010, 2'b01, 1'b1, 1'b1, 16'hFFAB);
        exp_both("lane1", 1, 16'hAB34);
        tick();
        drive(1'b1, 4'b0010, 2'b01, 1'b1, 1'b0, 16'h77CD);
        exp_both("lane0", 1, 16'hABCD);
        tick();

        // Boundary at all-ones.
        drive(1'b1, 4'b0001, 2'b01, 1'b0, 1'b0, 16'hFFFF);
        exp_both("r0_ffff", 0, 16'hFFFF);
        exp_evt("evt_load", 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'b0001, 2'b11, 1'b0, 1'b0, 16'h0000);
        exp_reg("inc_top", 0, 0, 16'h0000);
        exp_reg("inc_top", 1, 0, 16'hFFFF);
        exp_evt("inc_top_evt", 1'b1, 1'b1);
        tick();
        drive(1'b1, 4'b0001, 2'b10, 1'b0, 1'b0, 16'h0000);
        exp_reg("dec_after", 0, 0, 16'hFFFF);
        exp_reg("dec_after", 1, 0, 16'hFFFE);
        exp_evt("dec_after_evt", 1'b1, 1'b0);
        tick();
        drive(1'b1, 4'b0000, 2'b11, 1'b0, 1'b0, 16'h0000);
        exp_reg("idle_hold", 0, 0, 16'hFFFF);
        exp_evt("idle_evt", 1'b0, 1'b0);
        tick();

        // Boundary at zero, three decrements.
        drive(1'b1, 4'b0001, 2'b00, 1'b0, 1'b0, 16'h0000);
        exp_both("r0_zero", 0, 16'h0000);
        tick();
        drive(1'b1, 4'b0001, 2'b10, 1'b0, 1'b0, 16'h0000);
        exp_reg("dec1", 0, 0, 16'hFFFF); exp_reg("dec1", 1, 0, 16'h0000);
        exp_evt("dec1_evt", 1'b1, 1'b1);
        tick();
        exp_reg("dec2", 0, 0, 16'hFFFE); exp_reg("dec2", 1, 0, 16'h0000);
        exp_evt("dec2_evt", 1'b0, 1'b1);
        tick();
        exp_reg("dec3", 0, 0, 16'hFFFD); exp_reg("dec3", 1, 0, 16'h0000);
        exp_evt("dec3_evt", 1'b0, 1'b1);
        tick();

        // Approach all-ones by increment.
        drive(1'b1, 4'b0001, 2'b01, 1'b0, 1'b0, 16'hFFFE);
        exp_both("r0_fffe", 0, 16'hFFFE);
        tick();
        drive(1'b1, 4'b0001, 2'b11, 1'b0, 1'b0, 16'h0000);
        exp_both("inc1", 0, 16'hFFFF);
        exp_evt("inc1_evt", 1'b0, 1'b0);
        tick();
        exp_reg("inc2", 0, 0, 16'h0000); exp_reg("inc2", 1, 0, 16'hFFFF);
        exp_evt("inc2_evt", 1'b1, 1'b1);
        tick();

        // Both read ports on the same register.
        drive(1'b1, 4'b0000, 2'b00, 1'b0, 1'b0, 16'h0000);
        sel_a = 2'd2; sel_b = 2'd2;
        #1;
        vectors++;
        assert (out_a_w === 16'h1234 && out_b_w === 16'h1234)
        else begin
            miscompares++;
            $error("FAIL same_sel: observed a=%h b=%h expected 1234", out_a_w, out_b_w);
        end
        $display("check same_sel a=%h b=%h exp=1234", out_a_w, out_b_w);
        push("same_sel_b", 1, 1, 2, 16'h1234);
        tick();

        // Reset mid-increment on every register.
        drive(1'b1, 4'b0001, 2'b01, 1'b0, 1'b0, 16'hFFFF);
        tick();
        drive(1'b1, 4'b0001, 2'b11, 1'b0, 1'b0, 16'h0000);
        exp_evt("pre_rst_evt", 1'b1, 1'b1);
        tick();
        drive(1'b0, 4'hF, 2'b11, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            exp_reg("rst_mid", 0, i, 16'h0000);
            exp_reg("rst_mid", 1, i, 16'hA5A5);
        end
        exp_evt("rst_mid_evt", 1'b0, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
